// File: rtl/m31_mod_reduce_pipe.sv
// m31_mod_reduce_pipe
// Elastic pipeline that reduces every lane of an input word modulo the
// Mersenne prime p = 2^31-1. Each stage folds x into x[30:0] + (x >> 31)
// until the value is at most 2^31. A registered finalize stage then maps
// the value into [0, p-1], or into [0, p] when CANONICAL=0.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   flush        synchronous drop of all in-flight words (blocks input that cycle)
//   in_valid     input word valid
//   in_ready     input word accepted
//   in_data      LANES x IN_WIDTH input lanes
//   in_tag       sideband tag that travels with the word
//   out_valid    result valid
//   out_ready    consumer accepts the result
//   out_data     LANES x 31 result lanes
//   out_tag      tag of the word on out_data
//   busy         any stage holds valid data
module m31_mod_reduce_pipe #(
    parameter int IN_WIDTH  = 64,
    parameter int LANES     = 1,
    parameter int TAG_WIDTH = 1,
    parameter bit CANONICAL = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*IN_WIDTH-1:0] in_data,
    input  logic [TAG_WIDTH-1:0]      in_tag,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [LANES*31-1:0]       out_data,
    output logic [TAG_WIDTH-1:0]      out_tag,
    output logic                      busy
);

    localparam logic [65:0] P_WIDE = 66'h7FFF_FFFF;
    localparam logic [30:0] P      = 31'h7FFF_FFFF;

    // Upper bound of a value after one fold.
    function automatic logic [65:0] fold_bound(input logic [65:0] b);
        return P_WIDE + (b >> 31);
    endfunction

    // Number of bits needed to hold the value b.
    function automatic int unsigned bit_width(input logic [65:0] b);
        int unsigned w;
        w = 1;
        for (int unsigned i = 0; i < 66; i++) begin
            if (b[i]) w = i + 1;
        end
        return w;
    endfunction

    localparam int unsigned NUM_FOLDS = (IN_WIDTH >= 63) ? 3 : 2;
    localparam logic [65:0] B0 = (66'd1 << IN_WIDTH) - 66'd1;
    localparam logic [65:0] B1 = fold_bound(B0);
    localparam logic [65:0] B2 = fold_bound(B1);
    localparam int unsigned W1 = bit_width(B1);
    localparam int unsigned W2 = bit_width(B2);

    if (IN_WIDTH < 32 || IN_WIDTH > 64) begin : g_bad_in_width
        $error("m31_mod_reduce_pipe: IN_WIDTH=%0d outside 32..64", IN_WIDTH);
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("m31_mod_reduce_pipe: LANES=%0d must be at least 1", LANES);
    end
    if (TAG_WIDTH < 1) begin : g_bad_tag_width
        $error("m31_mod_reduce_pipe: TAG_WIDTH=%0d must be at least 1", TAG_WIDTH);
    end

    logic                 v1, v2, vy;
    logic                 rdy_1, rdy_2, rdy_y, rdy_fin;
    logic [TAG_WIDTH-1:0] t1, t2, ty;
    logic [W1-1:0]        f1 [LANES];
    logic [W1-1:0]        d1 [LANES];
    logic [W2-1:0]        f2 [LANES];
    logic [W2-1:0]        d2 [LANES];
    logic [31:0]          dy [LANES];
    logic [30:0]          z  [LANES];

    // Backward ready chain: a stage may load when it is empty or its
    // content moves on this cycle, so bubbles collapse under a stall.
    assign rdy_fin  = !out_valid || out_ready;
    assign rdy_2    = !v2 || rdy_y;
    assign rdy_1    = !v1 || rdy_2;
    assign in_ready = rdy_1 && !flush;
    assign busy     = v1 || v2 || vy || out_valid;

    // Fold 1: straight from the input lanes.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            f1[i] = W1'(in_data[i*IN_WIDTH +: 31])
                  + W1'(in_data[i*IN_WIDTH + 31 +: IN_WIDTH - 31]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            t1 <= '0;
            for (int unsigned i = 0; i < LANES; i++) d1[i] <= '0;
        end else if (flush) begin
            v1 <= 1'b0;
        end else if (rdy_1) begin
            v1 <= in_valid;
            if (in_valid) begin
                t1 <= in_tag;
                for (int unsigned i = 0; i < LANES; i++) d1[i] <= f1[i];
            end
        end
    end

    // Fold 2.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            f2[i] = W2'(d1[i][30:0]) + W2'(d1[i][W1-1:31]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            t2 <= '0;
            for (int unsigned i = 0; i < LANES; i++) d2[i] <= '0;
        end else if (flush) begin
            v2 <= 1'b0;
        end else if (rdy_2) begin
            v2 <= v1;
            if (v1) begin
                t2 <= t1;
                for (int unsigned i = 0; i < LANES; i++) d2[i] <= f2[i];
            end
        end
    end

    // Inputs wider than 62 bits need a third fold to reach <= 2^31;
    // either way the finalize stage sees a uniform 32-bit value y.
    if (NUM_FOLDS == 3) begin : g_fold3
        localparam logic [65:0] B3 = fold_bound(B2);
        localparam int unsigned W3 = bit_width(B3);

        logic                 v3;
        logic [TAG_WIDTH-1:0] t3;
        logic [W3-1:0]        f3 [LANES];
        logic [W3-1:0]        d3 [LANES];

        always_comb begin
            for (int unsigned i = 0; i < LANES; i++) begin
                f3[i] = W3'(d2[i][30:0]) + W3'(d2[i][W2-1:31]);
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v3 <= 1'b0;
                t3 <= '0;
                for (int unsigned i = 0; i < LANES; i++) d3[i] <= '0;
            end else if (flush) begin
                v3 <= 1'b0;
            end else if (rdy_y) begin
                v3 <= v2;
                if (v2) begin
                    t3 <= t2;
                    for (int unsigned i = 0; i < LANES; i++) d3[i] <= f3[i];
                end
            end
        end

        assign rdy_y = !v3 || rdy_fin;
        assign vy    = v3;
        assign ty    = t3;
        always_comb begin
            for (int unsigned i = 0; i < LANES; i++) dy[i] = 32'(d3[i]);
        end
    end else begin : g_fold2
        assign rdy_y = rdy_fin;
        assign vy    = v2;
        assign ty    = t2;
        always_comb begin
            for (int unsigned i = 0; i < LANES; i++) dy[i] = 32'(d2[i]);
        end
    end

    // Finalize: y <= 2^31, so y[30:0] + y[31] <= p and never overflows 31 bits.
    always_comb begin
        for (int unsigned i = 0; i < LANES; i++) begin
            z[i] = dy[i][30:0] + 31'(dy[i][31]);
            if (CANONICAL && z[i] == P) z[i] = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_tag   <= '0;
            out_data  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (rdy_fin) begin
            out_valid <= vy;
            if (vy) begin
                out_tag <= ty;
                for (int unsigned i = 0; i < LANES; i++) out_data[i*31 +: 31] <= z[i];
            end
        end
    end

endmodule

// File: tb/tb_m31_mod_reduce_pipe.sv
// Testbench for m31_mod_reduce_pipe. Two instances: a 3-lane 64-bit canonical
// pipeline (three folds) and a 1-lane 62-bit non-canonical one (two folds).
// Expected results come from x % p computed here and are queued at the input
// handshake, then compared at the output handshake.
module tb_m31_mod_reduce_pipe;

    localparam int              LANES  = 3;
    localparam int              TW     = 4;
    localparam longint unsigned P      = 64'h7FFF_FFFF;
    localparam int              NWORDS = 15000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                  rst_n, flush, in_valid, in_ready, out_valid, out_ready, busy;
    logic [LANES*64-1:0]   in_data;
    logic [TW-1:0]         in_tag, out_tag;
    logic [LANES*31-1:0]   out_data;

    logic                  flush2, in_valid2, in_ready2, out_valid2, out_ready2, busy2;
    logic [61:0]           in_data2;
    logic                  in_tag2, out_tag2;
    logic [30:0]           out_data2;

    m31_mod_reduce_pipe #(.IN_WIDTH(64), .LANES(LANES), .TAG_WIDTH(TW), .CANONICAL(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
        .busy(busy)
    );

    m31_mod_reduce_pipe #(.IN_WIDTH(62), .LANES(1), .TAG_WIDTH(1), .CANONICAL(1'b0)) u_dut62 (
        .clk(clk), .rst_n(rst_n), .flush(flush2),
        .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_tag(in_tag2),
        .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_tag(out_tag2),
        .busy(busy2)
    );

    typedef struct {
        logic [LANES*31-1:0] data;
        logic [TW-1:0]       tag;
        int                  cyc;
    } entry_t;

    typedef struct {
        logic [30:0] data;
        logic        tag;
        int          cyc;
    } entry2_t;

    entry_t  q[$];
    entry2_t q2[$];
    int      n_checks = 0;
    int      n_fail   = 0;
    int      cyc      = 0;
    bit      chk_lat  = 1'b0;
    bit      acc      = 1'b0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [LANES*31-1:0] ref_mod(input logic [LANES*64-1:0] d);
        logic [LANES*31-1:0] r;
        longint unsigned     x;
        for (int i = 0; i < LANES; i++) begin
            x = d[i*64 +: 64];
            r[i*31 +: 31] = 31'(x % P);
        end
        return r;
    endfunction

    function automatic logic [63:0] rand_lane();
        case ($urandom_range(0, 5))
            0: return P * 64'($urandom_range(0, 9));
            1: return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            2: return 64'(1) << $urandom_range(0, 63);
            3: return 64'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic logic [LANES*64-1:0] rand_word();
        logic [LANES*64-1:0] w;
        for (int i = 0; i < LANES; i++) w[i*64 +: 64] = rand_lane();
        return w;
    endfunction

    // One clock cycle, entered and left at a falling edge. Outputs and
    // handshakes are evaluated 1 time unit after the falling edge.
    task automatic step();
        entry_t      e;
        entry2_t     e2;
        logic [30:0] o2;
        #1;
        acc = in_valid && in_ready;
        check("in_ready", 128'(in_ready), 128'(!flush && !(q.size() == 4 && !out_ready)));
        check("busy", 128'(busy), 128'(q.size() != 0));
        if (out_valid) begin
            if (q.size() == 0) begin
                check("spurious_out", 128'(out_valid), 128'(0));
            end else begin
                check("out_data", 128'(out_data), 128'(q[0].data));
                check("out_tag", 128'(out_tag), 128'(q[0].tag));
                if (out_ready) begin
                    if (chk_lat) check("latency", 128'(cyc - q[0].cyc), 128'(4));
                    void'(q.pop_front());
                end
            end
        end
        if (acc) begin
            e.data = ref_mod(in_data);
            e.tag  = in_tag;
            e.cyc  = cyc;
            q.push_back(e);
        end

        check("in_ready2", 128'(in_ready2), 128'(1));
        if (out_valid2) begin
            if (q2.size() == 0) begin
                check("spurious_out2", 128'(out_valid2), 128'(0));
            end else begin
                // p is a legal spelling of 0 in this configuration
                o2 = (out_data2 == 31'h7FFF_FFFF) ? 31'd0 : out_data2;
                check("out_data2", 128'(o2), 128'(q2[0].data));
                check("out_tag2", 128'(out_tag2), 128'(q2[0].tag));
                check("latency2", 128'(cyc - q2[0].cyc), 128'(3));
                void'(q2.pop_front());
            end
        end
        if (in_valid2 && in_ready2) begin
            e2.data = 31'(64'(in_data2) % P);
            e2.tag  = in_tag2;
            e2.cyc  = cyc;
            q2.push_back(e2);
        end

        @(posedge clk);
        if (flush) q.delete();
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input logic [LANES*64-1:0] d, input logic [TW-1:0] t);
        int k;
        in_valid = 1'b1;
        in_data  = d;
        in_tag   = t;
        k = 0;
        do begin
            step();
            k++;
        end while (!acc && k < 100);
        check("send_accept", 128'(acc), 128'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int k;
        in_valid  = 1'b0;
        in_valid2 = 1'b0;
        out_ready = 1'b1;
        k = 0;
        while ((q.size() != 0 || q2.size() != 0) && k < 100) begin
            step();
            k++;
        end
        check("drain_left", 128'(q.size() + q2.size()), 128'(0));
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int nt;
        int nacc;
        int sent;
        int guard;

        rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; out_ready = 1'b1;
        flush2 = 1'b0; in_valid2 = 1'b0; in_data2 = '0; in_tag2 = 1'b0; out_ready2 = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);

        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_out_data", 128'(out_data), 128'(0));
        check("rst_out_tag", 128'(out_tag), 128'(0));
        check("rst_out_valid2", 128'(out_valid2), 128'(0));
        step();
        step();
        rst_n = 1'b1;
        step();

        // Edge values at full rate, fixed latency
        chk_lat = 1'b1;
        send({64'd0, 64'd0, 64'h7FFF_FFFF}, 4'd1);
        send({64'd0, 64'd0, 64'hFFFF_FFFF}, 4'd2);
        send({64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF}, 4'd3);
        send({64'd0, 64'd0, 64'd0}, 4'd4);
        send({64'd5, 64'h4000_0000_0000_0000, 64'h8000_0000}, 4'hA);
        drain();

        // 62-bit non-canonical instance
        in_valid2 = 1'b1;
        in_data2  = 62'h7FFF_FFFF;           in_tag2 = 1'b1; step();
        in_data2  = 62'h8000_0000;           in_tag2 = 1'b0; step();
        in_data2  = 62'h3FFF_FFFF_FFFF_FFFF; in_tag2 = 1'b1; step();
        in_data2  = 62'h3FFF_FFFF_8000_0000; in_tag2 = 1'b0; step();
        in_valid2 = 1'b0;
        drain();

        // Backpressure: four words fill the pipe, then input stalls
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        nt = 1;
        nacc = 0;
        in_data = rand_word();
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            in_tag   = TW'(nt);
            step();
            if (acc) begin
                nt++;
                nacc++;
                in_data = rand_word();
            end
        end
        check("bp_accepts", 128'(nacc), 128'(4));
        out_ready = 1'b1;
        guard = 0;
        while (nt <= 6 && guard < 50) begin
            in_valid = 1'b1;
            in_tag   = TW'(nt);
            step();
            if (acc) begin
                nt++;
                in_data = rand_word();
            end
            guard++;
        end
        check("bp_all_sent", 128'(nt), 128'(7));
        drain();

        // Asynchronous reset with words in flight
        out_ready = 1'b0;
        send(rand_word(), 4'd1);
        send(rand_word(), 4'd2);
        send(rand_word(), 4'd3);
        idle(4);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_out_valid", 128'(out_valid), 128'(0));
        check("rst_async_busy", 128'(busy), 128'(0));
        check("rst_async_in_ready", 128'(in_ready), 128'(1));
        q.delete();
        q2.delete();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        idle(8);

        // Flush with words in flight; the word offered in the flush cycle is refused
        out_ready = 1'b0;
        send(rand_word(), 4'd4);
        send(rand_word(), 4'd5);
        send(rand_word(), 4'd6);
        idle(4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = rand_word();
        in_tag   = 4'd7;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_busy", 128'(busy), 128'(0));
        check("flush_out_valid", 128'(out_valid), 128'(0));
        out_ready = 1'b1;
        idle(8);

        // Random traffic on both instances
        sent = 0;
        guard = 0;
        in_valid = 1'b0;
        while (sent < NWORDS && guard < 60000) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                in_data  = rand_word();
                in_tag   = TW'($urandom);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid2 = $urandom_range(0, 1) == 1;
            in_tag2   = $urandom_range(0, 1) == 1;
            in_data2  = ($urandom_range(0, 7) == 0) ? 62'h3FFF_FFFF_FFFF_FFFF
                                                    : 62'({$urandom, $urandom});
            step();
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
            guard++;
        end
        check("random_sent", 128'(sent), 128'(NWORDS));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
